// File: rtl/uart_avms_host.sv
// uart_avms_host: Avalon-MM initiator for the uart_core register slave.
// Buffers TX bytes, polls STATUS, writes TXDATA and fetches RXDATA.
module uart_avms_host #(
    parameter int TX_FIFO_DEPTH = 4,
    parameter int POLL_GAP      = 3,
    parameter int READ_LATENCY  = 1,
    parameter int POLL_PERIOD   = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic [3:0] avms_address_o,
    output logic       avms_byteenable_o,
    output logic       avms_read_o,
    output logic       avms_write_o,
    output logic [7:0] avms_writedata_o,
    input  logic [7:0] avms_readdata_i,
    input  logic       irq_i,
    output logic [7:0] status_o,
    output logic       busy_o
);

    localparam int AW   = $clog2(TX_FIFO_DEPTH);
    localparam int CMAX = (POLL_GAP > READ_LATENCY) ? POLL_GAP : READ_LATENCY;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = (POLL_PERIOD > 0) ? $clog2(POLL_PERIOD + 1) : 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GAP       = 3'd1;
    localparam logic [2:0] ST_RD_STAT   = 3'd2;
    localparam logic [2:0] ST_WAIT_STAT = 3'd3;
    localparam logic [2:0] ST_WR_TX     = 3'd4;
    localparam logic [2:0] ST_RD_RX     = 3'd5;
    localparam logic [2:0] ST_WAIT_RX   = 3'd6;

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_RXDATA = 4'h2;

    logic [2:0]    state_q, state_d;
    logic [2:0]    tgt_q, tgt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    status_q, status_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          irq_pend_q, irq_pend_d;

    logic [7:0]    mem_q [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fcnt_q, fcnt_d;

    logic fifo_full;
    logic fifo_nempty;
    logic push;
    logic pop;
    logic poll_due;
    logic lat_done;
    logic gap_done;

    assign fifo_full   = (fcnt_q == (AW+1)'(TX_FIFO_DEPTH));
    assign fifo_nempty = (fcnt_q != '0);
    assign push        = tx_valid_i & ~fifo_full;
    assign pop         = (state_q == ST_WR_TX);
    assign poll_due    = (POLL_PERIOD != 0) && (timer_q == TW'(POLL_PERIOD));
    assign lat_done    = (cnt_q == CW'(READ_LATENCY - 1));
    assign gap_done    = (cnt_q == CW'(POLL_GAP - 1));

    // FIFO pointer and occupancy update; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case (1'b1)
            push & ~pop: fcnt_d = fcnt_q + (AW+1)'(1);
            pop & ~push: fcnt_d = fcnt_q - (AW+1)'(1);
            default:     fcnt_d = fcnt_q;
        endcase
    end

    // Bus sequencing FSM, status/RX capture and IRQ bookkeeping.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        status_d   = status_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        irq_pend_d = irq_i | (irq_pend_q & (state_q != ST_RD_RX));
        if (rx_valid_q & rx_ready_i) begin
            rx_valid_d = 1'b0;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (fifo_nempty | irq_pend_q | poll_due) begin
                    state_d = ST_GAP;
                    tgt_d   = ST_RD_STAT;
                    cnt_d   = '0;
                    timer_d = '0;
                end else if (POLL_PERIOD != 0) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_d = tgt_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RD_STAT: begin
                state_d = ST_WAIT_STAT;
                cnt_d   = '0;
            end
            ST_WAIT_STAT: begin
                if (lat_done) begin
                    status_d = avms_readdata_i;
                    cnt_d    = '0;
                    if (avms_readdata_i[1] & ~rx_valid_q) begin
                        state_d = ST_GAP;
                        tgt_d   = ST_RD_RX;
                    end else if (avms_readdata_i[0] & fifo_nempty) begin
                        state_d = ST_GAP;
                        tgt_d   = ST_WR_TX;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WR_TX: begin
                state_d = ST_IDLE;
            end
            ST_RD_RX: begin
                state_d = ST_WAIT_RX;
                cnt_d   = '0;
            end
            ST_WAIT_RX: begin
                if (lat_done) begin
                    rx_data_d  = avms_readdata_i;
                    rx_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            tgt_q      <= ST_RD_STAT;
            cnt_q      <= '0;
            timer_q    <= '0;
            status_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            irq_pend_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            status_q   <= status_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            irq_pend_q <= irq_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // FIFO storage; contents are meaningless once the pointers reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data_i;
        end
    end

    // Bus outputs decoded from the registered state only.
    always_comb begin
        avms_read_o       = 1'b0;
        avms_write_o      = 1'b0;
        avms_byteenable_o = 1'b0;
        avms_writedata_o  = 8'h00;
        avms_address_o    = ADDR_STATUS;
        unique case (state_q)
            ST_RD_STAT: begin
                avms_read_o    = 1'b1;
                avms_address_o = ADDR_STATUS;
            end
            ST_WR_TX: begin
                avms_write_o      = 1'b1;
                avms_byteenable_o = 1'b1;
                avms_writedata_o  = mem_q[rd_ptr_q];
                avms_address_o    = ADDR_TXDATA;
            end
            ST_RD_RX: begin
                avms_read_o    = 1'b1;
                avms_address_o = ADDR_RXDATA;
            end
            default: begin
                avms_address_o = ADDR_STATUS;
            end
        endcase
    end

    assign tx_ready_o = ~fifo_full;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign status_o   = status_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
